aes_fault_sequencer: RTL and testbench

Sequences a differential-fault-analysis (DFA) campaign on the `aes_128` core, which is held at a fixed state and key. Optionally runs one fault-free (golden) encryption first. It then runs one faulted encryption per fault bit in a programmed range: it drives the core's `fault_en` and `fault_bit`, waits for the core pipeline to settle, captures the ciphertext, and hands each result downstream over a valid/ready interface. It sits between the campaign top level and `aes_128`, and replaces directly driven fault pins.

---
 rtl/aes_fault_sequencer.sv | 123 ++++++++++++
 tb/tb_aes_fault_sequencer.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_fault_sequencer.sv
// Drives a DFA campaign on aes_128: an optional golden run, then one faulted
// encryption per bit in [bit_first, bit_last], with results handed out over valid/ready.
module aes_fault_sequencer #(
  parameter int SETTLE = 22,
  parameter int CW     = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         golden_en,
  input  logic [6:0]   bit_first,
  input  logic [6:0]   bit_last,
  input  logic [127:0] aes_ct,
  output logic         fault_en,
  output logic [6:0]   fault_bit,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [127:0] res_ct,
  output logic [6:0]   res_bit,
  output logic         res_faulted,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {IDLE, GOLD, FAULT, OUT, FIN} state_t;

  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

  state_t      state;
  logic [CW-1:0] cnt;
  logic        armed;
  logic        range_ok;
  logic [6:0]  last_q;
  logic [6:0]  cur_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      armed       <= 1'b0;
      range_ok    <= 1'b0;
      last_q      <= '0;
      cur_bit     <= '0;
      fault_en    <= 1'b0;
      fault_bit   <= '0;
      res_valid   <= 1'b0;
      res_ct      <= '0;
      res_bit     <= '0;
      res_faulted <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            range_ok <= (bit_first <= bit_last);
            last_q   <= bit_last;
            cur_bit  <= bit_first;
            cnt      <= '0;
            armed    <= 1'b0;
            busy     <= 1'b1;
            if (golden_en) begin
              state     <= GOLD;
              fault_en  <= 1'b0;
              fault_bit <= '0;
            end else if (bit_first <= bit_last) begin
              state     <= FAULT;
              fault_en  <= 1'b1;
              fault_bit <= bit_first;
            end else begin
              state <= FIN;
              done  <= 1'b1;
            end
          end
        end
        GOLD, FAULT: begin
          // First cycle lets the freshly registered fault pins reach the core;
          // the settle count runs from the cycle after.
          if (!armed) begin
            armed <= 1'b1;
          end else if (cnt == CNT_LAST) begin
            res_ct      <= aes_ct;
            res_faulted <= (state == FAULT);
            res_bit     <= (state == FAULT) ? cur_bit : 7'd0;
            res_valid   <= 1'b1;
            fault_en    <= 1'b0;
            state       <= OUT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        OUT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            cnt       <= '0;
            armed     <= 1'b0;
            if (!res_faulted && range_ok) begin
              state     <= FAULT;
              fault_en  <= 1'b1;
              fault_bit <= cur_bit;
            end else if (res_faulted && cur_bit != last_q) begin
              // Equality end test before increment: bit 127 never wraps.
              cur_bit   <= cur_bit + 7'd1;
              fault_bit <= cur_bit + 7'd1;
              fault_en  <= 1'b1;
              state     <= FAULT;
            end else begin
              state <= FIN;
              done  <= 1'b1;
            end
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_fault_sequencer.sv
// Bench for aes_fault_sequencer: a delay-line stub stands in for aes_128, and
// results are checked against a list built directly from the campaign range.
module tb_aes_fault_sequencer;
  localparam int LAT = 23;

  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, golden_en = 1'b0, res_ready = 1'b0;
  logic [6:0]   bit_first = '0, bit_last = '0;
  logic [127:0] aes_ct, res_ct;
  logic         fault_en, res_valid, res_faulted, busy, done;
  logic [6:0]   fault_bit, res_bit;

  int asserts = 0, fails = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Core stub: fault pins through a 21-stage delay line.
  logic [7:0] dly [21];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) for (int i = 0; i < 21; i++) dly[i] <= '0;
    else begin
      dly[0] <= {fault_en, fault_bit};
      for (int i = 1; i < 21; i++) dly[i] <= dly[i-1];
    end
  end
  assign aes_ct = 128'hC0DE ^ ({127'b0, dly[20][7]} << dly[20][6:0]);

  aes_fault_sequencer #(.SETTLE(22), .CW(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .golden_en(golden_en),
    .bit_first(bit_first), .bit_last(bit_last), .aes_ct(aes_ct),
    .fault_en(fault_en), .fault_bit(fault_bit), .res_valid(res_valid),
    .res_ready(res_ready), .res_ct(res_ct), .res_bit(res_bit),
    .res_faulted(res_faulted), .busy(busy), .done(done)
  );

  logic [127:0] r_ct[$], e_ct[$];
  int           r_bit[$], e_bit[$], r_vcyc[$], r_hs[$];
  bit           r_flt[$], e_flt[$];
  int           start_cyc, done_cnt, done_cyc, busy_fall, bad_hold;
  bit           timeout;

  task automatic build_exp(input bit g, input int f, input int l);
    e_ct.delete(); e_bit.delete(); e_flt.delete();
    if (g) begin e_ct.push_back(128'hC0DE); e_bit.push_back(0); e_flt.push_back(1'b0); end
    for (int b = f; b <= l; b++) begin
      e_ct.push_back(128'hC0DE ^ (128'd1 << b)); e_bit.push_back(b); e_flt.push_back(1'b1);
    end
  endtask

  task automatic do_start(input bit g, input int f, input int l);
    @(negedge clk);
    golden_en = g; bit_first = 7'(f); bit_last = 7'(l); start = 1'b1;
    start_cyc = cyc + 1;
  endtask

  // Runs the handshake side until done+idle or the cycle limit; records results.
  task automatic collect(input int limit, input int pct, input int hold, input int poke);
    bit pend = 0, pv = 0;
    logic [127:0] hct = '0; logic [6:0] hbit = '0; logic hflt = 0;
    int hold_left = hold;
    r_ct.delete(); r_bit.delete(); r_flt.delete(); r_vcyc.delete(); r_hs.delete();
    done_cnt = 0; done_cyc = -1; busy_fall = -1; bad_hold = 0; timeout = 1;
    for (int n = 0; n < limit; n++) begin
      @(negedge clk);
      start = (poke > 0 && n == poke);
      if (start) begin golden_en = 1'b1; bit_first = 7'd50; bit_last = 7'd60; end
      if (pend && (res_valid !== 1'b1 || res_ct !== hct || res_bit !== hbit || res_faulted !== hflt))
        bad_hold++;
      if (res_valid && fault_en) bad_hold++;
      if (res_valid && !pv) r_vcyc.push_back(cyc);
      if (res_valid && hold_left > 0) begin res_ready = 1'b0; hold_left--; end
      else res_ready = ($urandom_range(1, 100) <= pct);
      if (res_valid && res_ready) begin
        r_ct.push_back(res_ct); r_bit.push_back(int'(res_bit)); r_flt.push_back(res_faulted);
        r_hs.push_back(cyc + 1);
      end
      pend = res_valid && !res_ready; hct = res_ct; hbit = res_bit; hflt = res_faulted;
      pv = res_valid;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (done_cnt > 0 && !busy) begin busy_fall = cyc; timeout = 0; break; end
    end
    res_ready = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    asserts++;
    if ({fault_en, fault_bit, res_valid, res_ct, res_bit, res_faulted, busy, done} !== '0) begin
      fails++; $display("FAIL reset_outputs: got ct %h busy %b fe %b, want all zero", res_ct, busy, fault_en);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_golden_only;
    build_exp(1, 5, 4);
    do_start(1, 5, 4);
    collect(200, 100, 0, 0);
    asserts++;
    if (timeout || r_ct.size() != 1) begin
      fails++; $display("FAIL golden_count: got %0d results timeout %0b, want 1", r_ct.size(), timeout);
    end else begin
      asserts++;
      if (r_ct[0] !== e_ct[0] || r_flt[0] !== e_flt[0] || r_bit[0] !== e_bit[0]) begin
        fails++; $display("FAIL golden_res: got ct %h flt %0b bit %0d, want ct %h flt 0 bit 0", r_ct[0], r_flt[0], r_bit[0], e_ct[0]);
      end
      asserts++;
      if (r_vcyc[0] - start_cyc !== LAT) begin
        fails++; $display("FAIL golden_latency: got %0d want %0d", r_vcyc[0] - start_cyc, LAT);
      end
      asserts++;
      if (done_cnt !== 1 || done_cyc !== r_hs[0]) begin
        fails++; $display("FAIL golden_done: got cnt %0d at %0d, want 1 at %0d", done_cnt, done_cyc, r_hs[0]);
      end
      asserts++;
      if (busy_fall !== done_cyc + 1) begin
        fails++; $display("FAIL golden_busy_fall: got %0d want %0d", busy_fall, done_cyc + 1);
      end
    end
  endtask

  task automatic test_full_sweep;
    build_exp(0, 0, 127);
    do_start(0, 0, 127);
    collect(4000, 100, 0, 0);
    asserts++;
    if (timeout || r_ct.size() != 128 || done_cnt != 1) begin
      fails++; $display("FAIL sweep_count: got %0d results done %0d timeout %0b, want 128 done 1", r_ct.size(), done_cnt, timeout);
    end
    for (int i = 0; i < r_ct.size() && i < 128; i++) begin
      asserts++;
      if (r_bit[i] !== e_bit[i] || r_ct[i] !== e_ct[i] || r_flt[i] !== e_flt[i]) begin
        fails++; $display("FAIL sweep_res[%0d]: got bit %0d flt %0b ct %h, want bit %0d flt 1 ct %h", i, r_bit[i], r_flt[i], r_ct[i], e_bit[i], e_ct[i]);
      end
    end
  endtask

  task automatic test_back_pressure;
    build_exp(0, 10, 11);
    do_start(0, 10, 11);
    collect(400, 100, 50, 0);
    asserts++;
    if (timeout || r_ct.size() != 2) begin
      fails++; $display("FAIL bp_count: got %0d results timeout %0b, want 2", r_ct.size(), timeout);
    end else begin
      asserts++;
      if (r_bit[0] !== 10 || r_ct[0] !== e_ct[0] || r_bit[1] !== 11 || r_ct[1] !== e_ct[1]) begin
        fails++; $display("FAIL bp_res: got bits %0d,%0d ct %h,%h want 10,11 ct %h,%h", r_bit[0], r_bit[1], r_ct[0], r_ct[1], e_ct[0], e_ct[1]);
      end
      asserts++;
      if (bad_hold !== 0) begin
        fails++; $display("FAIL bp_hold: got %0d unstable/fault_en cycles, want 0", bad_hold);
      end
      asserts++;
      if (r_hs[0] - r_vcyc[0] !== 51) begin
        fails++; $display("FAIL bp_stall: got handshake %0d cycles after valid, want 51", r_hs[0] - r_vcyc[0]);
      end
      asserts++;
      if (r_vcyc[1] - r_hs[0] !== LAT) begin
        fails++; $display("FAIL bp_next_latency: got %0d want %0d", r_vcyc[1] - r_hs[0], LAT);
      end
    end
  endtask

  task automatic test_start_busy;
    build_exp(0, 20, 22);
    do_start(0, 20, 22);
    collect(500, 100, 0, 30);
    asserts++;
    if (timeout || r_ct.size() != 3 || done_cnt != 1) begin
      fails++; $display("FAIL busy_start_count: got %0d results done %0d, want 3 done 1", r_ct.size(), done_cnt);
    end
    for (int i = 0; i < r_ct.size() && i < 3; i++) begin
      asserts++;
      if (r_bit[i] !== e_bit[i] || r_ct[i] !== e_ct[i] || r_flt[i] !== 1'b1) begin
        fails++; $display("FAIL busy_start_res[%0d]: got bit %0d ct %h, want bit %0d ct %h", i, r_bit[i], r_ct[i], e_bit[i], e_ct[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    int seen = 0, stray = 0;
    do_start(0, 0, 5);
    res_ready = 1'b1;
    for (int n = 0; n < 400 && !seen; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (fault_en && fault_bit == 7'd3) seen = 1;
    end
    asserts++;
    if (!seen) begin fails++; $display("FAIL rst_mid_reach_bit3: got timeout, want FAULT on bit 3"); end
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    asserts++;
    if ({fault_en, fault_bit, res_valid, res_ct, res_bit, res_faulted, busy, done} !== '0) begin
      fails++; $display("FAIL rst_mid_outputs: got fe %b valid %b busy %b bit %0d, want all zero", fault_en, res_valid, busy, fault_bit);
    end
    @(negedge clk); rst_n = 1'b1; res_ready = 1'b0;
    repeat (20) begin @(negedge clk); if (done || busy || fault_en) stray++; end
    asserts++;
    if (stray !== 0) begin fails++; $display("FAIL rst_mid_idle: got %0d active cycles, want 0", stray); end
    build_exp(0, 7, 7);
    do_start(0, 7, 7);
    collect(200, 100, 0, 0);
    asserts++;
    if (timeout || r_ct.size() != 1 || done_cnt != 1 || r_bit[0] !== 7 || r_ct[0] !== e_ct[0]) begin
      fails++; $display("FAIL rst_mid_restart: got %0d results done %0d, want one result bit 7", r_ct.size(), done_cnt);
    end
  endtask

  task automatic test_random;
    for (int k = 0; k < 6; k++) begin
      bit g; int f, l, pct, ref_c;
      g = 1'($urandom_range(0, 1));
      f = $urandom_range(0, 127);
      if ($urandom_range(0, 4) == 0 && f > 0) l = f - 1;
      else begin l = f + $urandom_range(0, 3); if (l > 127) l = 127; end
      pct = $urandom_range(30, 100);
      build_exp(g, f, l);
      do_start(g, f, l);
      collect(1500, pct, 0, 0);
      asserts++;
      if (timeout || r_ct.size() != e_ct.size() || done_cnt != 1 || bad_hold != 0) begin
        fails++; $display("FAIL rand%0d_summary: got %0d results done %0d hold_err %0d, want %0d done 1 hold_err 0", k, r_ct.size(), done_cnt, bad_hold, e_ct.size());
      end
      for (int i = 0; i < r_ct.size() && i < e_ct.size(); i++) begin
        ref_c = (i == 0) ? start_cyc : r_hs[i-1];
        asserts++;
        if (r_bit[i] !== e_bit[i] || r_ct[i] !== e_ct[i] || r_flt[i] !== e_flt[i] || r_vcyc[i] - ref_c !== LAT) begin
          fails++; $display("FAIL rand%0d_res[%0d]: got bit %0d flt %0b lat %0d ct %h, want bit %0d flt %0b lat %0d ct %h", k, i, r_bit[i], r_flt[i], r_vcyc[i] - ref_c, r_ct[i], e_bit[i], e_flt[i], LAT, e_ct[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_golden_only;
    test_full_sweep;
    test_back_pressure;
    test_start_busy;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
